// File: rtl/uart_pkt_pkg.sv
// rtl/uart_pkt_pkg.sv - shared packet sizes and FSM state types for the UART packet scheduler
package uart_pkt_pkg;

   localparam int PKT_BYTES = 23;
   localparam int PKT_BITS  = PKT_BYTES * 8;

   typedef logic [PKT_BITS-1:0] pkt_t;

   typedef enum logic [1:0] {
      EMPTY,
      FILLING,
      FULL
   } fill_state_e;

   typedef enum logic {
      IDLE,
      PENDING
   } out_state_e;

endpackage

// File: rtl/uart_packet_scheduler_timer.sv
// rtl/uart_packet_scheduler_timer.sv - idle timer that flushes a partial packet (built only with UART_PKT_TIMEOUT_EN)
`ifdef UART_PKT_TIMEOUT_EN
module pkt_timeout_timer #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Expiry is flagged on the last idle clock so the flush lands exactly TIMEOUT_CYCLES edges after the byte.
   assign expired = enable & (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (restart) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`endif

// File: rtl/uart_packet_scheduler.sv
// rtl/uart_packet_scheduler.sv - assembles UART bytes into ping-pong packet banks for the modulator
// UART_PKT_TIMEOUT_EN adds an idle timer that flushes partial packets zero-padded.
module uart_packet_scheduler #(
   parameter int PKT_BYTES      = 23,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             rx_valid,
   input  logic [7:0]                       rx_data,
   input  logic                             clear,
   output logic [PKT_BYTES*8-1:0]           pkt_data,
   output logic [$clog2(PKT_BYTES+1)-1:0]   pkt_len,
   output logic                             pkt_valid,
   input  logic                             pkt_ready,
   output logic                             overrun,
   output logic                             busy
);

   import uart_pkt_pkg::*;

   localparam int PKT_BITS = PKT_BYTES * 8;
   localparam int IDX_W    = $clog2(PKT_BYTES + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_BYTES);

   fill_state_e          fill_q, fill_d;
   out_state_e           out_q, out_d;
   logic [IDX_W-1:0]     idx_q, idx_d, idx_inc;
   logic [PKT_BITS-1:0]  fill_bank_q, fill_bank_d, fill_bank_wr;
   logic [PKT_BITS-1:0]  out_bank_q, out_bank_d;
   logic [IDX_W-1:0]     out_len_q, out_len_d;
   logic                 overrun_q, overrun_d;
   logic                 wr, timeout_hit, full_now, out_free, swap;

`ifdef UART_PKT_TIMEOUT_EN
   logic tmr_expired;

   pkt_timeout_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .restart (wr | clear),
      .enable  (fill_q == FILLING),
      .expired (tmr_expired)
   );

   assign timeout_hit = tmr_expired & ~rx_valid & ~clear;
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      wr      = rx_valid & ~clear & (fill_q != FULL);
      idx_inc = idx_q + 1'b1;

      // The fill bank is zeroed whenever it empties, so unwritten bytes are already padding.
      fill_bank_wr = fill_bank_q;
      if (wr) begin
         fill_bank_wr[PKT_BITS-1-8*int'(idx_q) -: 8] = rx_data;
      end

      // A bank completing on this edge hands off immediately, making FULL transient when the out bank is free.
      full_now = ~clear & ((fill_q == FULL) | (wr & (idx_inc == IDX_LAST)) | timeout_hit);
      out_free = (out_q == IDLE) | pkt_ready;
      swap     = full_now & out_free;

      fill_d      = fill_q;
      idx_d       = idx_q;
      fill_bank_d = fill_bank_q;
      out_d       = out_q;
      out_bank_d  = out_bank_q;
      out_len_d   = out_len_q;
      overrun_d   = rx_valid & ~clear & (fill_q == FULL);

      if (clear || swap) begin
         fill_d      = EMPTY;
         idx_d       = '0;
         fill_bank_d = '0;
      end else if (full_now) begin
         fill_d      = FULL;
         idx_d       = wr ? idx_inc : idx_q;
         fill_bank_d = fill_bank_wr;
      end else if (wr) begin
         fill_d      = FILLING;
         idx_d       = idx_inc;
         fill_bank_d = fill_bank_wr;
      end

      if (swap) begin
         out_d      = PENDING;
         out_bank_d = fill_bank_wr;
         out_len_d  = wr ? idx_inc : idx_q;
      end else if ((out_q == PENDING) && pkt_ready) begin
         out_d = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_q      <= EMPTY;
         out_q       <= IDLE;
         idx_q       <= '0;
         fill_bank_q <= '0;
         out_bank_q  <= '0;
         out_len_q   <= '0;
         overrun_q   <= 1'b0;
      end else begin
         fill_q      <= fill_d;
         out_q       <= out_d;
         idx_q       <= idx_d;
         fill_bank_q <= fill_bank_d;
         out_bank_q  <= out_bank_d;
         out_len_q   <= out_len_d;
         overrun_q   <= overrun_d;
      end
   end

   assign pkt_data  = out_bank_q;
   assign pkt_len   = out_len_q;
   assign pkt_valid = (out_q == PENDING);
   assign overrun   = overrun_q;
   assign busy      = (fill_q != EMPTY) | pkt_valid;

endmodule

// File: tb/tb_uart_packet_scheduler.sv
// tb/tb_uart_packet_scheduler.sv - randomized and directed bench against a byte-queue reference model
module tb_uart_packet_scheduler;

   localparam int NB    = 23;
   localparam int NBITS = NB * 8;
   localparam int TO    = 50;

   logic             clk = 1'b0;
   logic             rst;
   logic             rx_valid;
   logic [7:0]       rx_data;
   logic             clear;
   logic [NBITS-1:0] pkt_data;
   logic [4:0]       pkt_len;
   logic             pkt_valid;
   logic             pkt_ready;
   logic             overrun;
   logic             busy;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: bytes waiting in the fill bank, and the packet on offer
   logic [7:0]       fq[$];
   bit               m_full;
   bit               m_valid;
   logic [NBITS-1:0] m_data;
   int               m_len;
   bit               m_ovr;
   int               idle;

   logic [NBITS-1:0] exp55;

   uart_packet_scheduler #(
      .PKT_BYTES      (NB),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .clear     (clear),
      .pkt_data  (pkt_data),
      .pkt_len   (pkt_len),
      .pkt_valid (pkt_valid),
      .pkt_ready (pkt_ready),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [NBITS-1:0] got, input logic [NBITS-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic model_reset();
      fq.delete();
      m_full  = 0;
      m_valid = 0;
      m_data  = '0;
      m_len   = 0;
      m_ovr   = 0;
      idle    = 0;
   endtask

   task automatic model_step(input bit v, input logic [7:0] d, input bit c, input bit r);
      bit out_free;
      out_free = !m_valid || r;
      m_ovr    = v && !c && m_full;
      if (c) begin
         fq.delete();
         m_full = 0;
         idle   = 0;
      end else if (v && !m_full) begin
         fq.push_back(d);
         idle = 0;
         if (fq.size() == NB) m_full = 1;
      end
`ifdef UART_PKT_TIMEOUT_EN
      else if (!v && !m_full && fq.size() > 0) begin
         if (idle == TO - 1) m_full = 1;
         else idle++;
      end
`endif
      if (!c && m_full && out_free) begin
         m_data = '0;
         foreach (fq[i]) m_data[NBITS-1-8*i -: 8] = fq[i];
         m_len   = fq.size();
         m_valid = 1;
         fq.delete();
         m_full  = 0;
      end else if (m_valid && r) begin
         m_valid = 0;
      end
   endtask

   task automatic check_all();
      check_eq("pkt_valid", pkt_valid, m_valid);
      check_eq("pkt_len", pkt_len, m_len);
      check_eq("pkt_data", pkt_data, m_data);
      check_eq("overrun", overrun, m_ovr);
      check_eq("busy", busy, (fq.size() > 0) || m_full || m_valid);
   endtask

   task automatic cycle(input bit v, input logic [7:0] d, input bit c, input bit r);
      rx_valid  = v;
      rx_data   = d;
      clear     = c;
      pkt_ready = r;
      @(posedge clk);
      model_step(v, d, c, r);
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      rx_valid  = 1'b0;
      rx_data   = 8'h00;
      clear     = 1'b0;
      pkt_ready = 1'b0;
      #1;
      check_eq("rst_valid", pkt_valid, 0);
      check_eq("rst_len", pkt_len, 0);
      check_eq("rst_data", pkt_data, 0);
      check_eq("rst_overrun", overrun, 0);
      check_eq("rst_busy", busy, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      do_reset();

      // single packet with the modulator ready
      for (int i = 1; i <= NB; i++) cycle(1, 8'(i), 0, 1);
      check_eq("t1_valid", pkt_valid, 1);
      check_eq("t1_first", pkt_data[NBITS-1 -: 8], 8'h01);
      check_eq("t1_last", pkt_data[7:0], 8'h17);
      check_eq("t1_len", pkt_len, NB);
      cycle(0, 8'h00, 0, 1);
      check_eq("t1_one_cycle", pkt_valid, 0);

      // two packets back-to-back while stalled
      for (int i = 1; i <= 2 * NB; i++) cycle(1, 8'(i), 0, 0);
      check_eq("t2_held_first", pkt_data[NBITS-1 -: 8], 8'h01);
      check_eq("t2_held_last", pkt_data[7:0], 8'h17);
      cycle(0, 8'h00, 0, 1);
      check_eq("t2_no_gap", pkt_valid, 1);
      check_eq("t2_second_first", pkt_data[NBITS-1 -: 8], 8'h18);
      check_eq("t2_second_last", pkt_data[7:0], 8'h2E);
      cycle(0, 8'h00, 0, 1);
      check_eq("t2_drained", pkt_valid, 0);

      // one byte too many while stalled
      for (int i = 1; i <= 2 * NB + 1; i++) cycle(1, 8'(i), 0, 0);
      check_eq("t3_overrun", overrun, 1);
      cycle(0, 8'h00, 0, 1);
      check_eq("t3_overrun_pulse", overrun, 0);
      check_eq("t3_second_first", pkt_data[NBITS-1 -: 8], 8'h18);
      check_eq("t3_second_last", pkt_data[7:0], 8'h2E);
      cycle(0, 8'h00, 0, 1);

      // clear with a simultaneous byte
      for (int i = 0; i < 10; i++) cycle(1, 8'($urandom), 0, 1);
      cycle(1, 8'hAA, 1, 1);
      check_eq("t4_clear_no_ovr", overrun, 0);
      for (int i = 0; i < NB; i++) cycle(1, 8'h55, 0, 1);
      exp55 = {NB{8'h55}};
      check_eq("t4_all55", pkt_data, exp55);
      cycle(0, 8'h00, 0, 1);

      // partial packet followed by idle
      for (int i = 0; i < 5; i++) cycle(1, 8'hC3, 0, 1);
      for (int i = 0; i < TO - 1; i++) cycle(0, 8'h00, 0, 1);
      check_eq("t5_not_yet", pkt_valid, 0);
      cycle(0, 8'h00, 0, 1);
`ifdef UART_PKT_TIMEOUT_EN
      check_eq("t5_flush_valid", pkt_valid, 1);
      check_eq("t5_flush_len", pkt_len, 5);
      check_eq("t5_pad", pkt_data[NBITS-41:0], 0);
      cycle(0, 8'h00, 0, 1);
`else
      check_eq("t5_no_flush", pkt_valid, 0);
      cycle(0, 8'h00, 1, 1);
`endif

      // reset mid-fill and while a packet is on offer
      for (int i = 0; i < 12; i++) cycle(1, 8'($urandom), 0, 1);
      do_reset();
      for (int i = 0; i < NB; i++) cycle(1, 8'($urandom), 0, 0);
      check_eq("t6_valid_before_rst", pkt_valid, 1);
      do_reset();
      for (int i = 1; i <= NB; i++) cycle(1, 8'(i + 100), 0, 1);
      check_eq("t6_clean_len", pkt_len, NB);
      check_eq("t6_clean_first", pkt_data[NBITS-1 -: 8], 8'd101);
      cycle(0, 8'h00, 0, 1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
